// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: byte FIFO, MSB-first bit timing, frame latch.
// Optional WS2812_INVERT_EN inverts led_out for an inverting level shifter.
module ws2812_tx #(
  parameter int T0H          = 14,
  parameter int T1H          = 28,
  parameter int TBIT         = 50,
  parameter int RESET_CYCLES = 2000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          led_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [CW-1:0] BIT_END = CW'(TBIT - 1);
  localparam logic [CW-1:0] LAT_END = CW'(RESET_CYCLES - 1);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(FIFO_DEPTH);

`ifdef WS2812_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    LATCH
  } state_t;

  // Byte FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign full  = (count == FULL_C);
  assign empty = (count == '0);
  assign push  = in_valid && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic          hi;
  logic          led_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        shift_d = head;
        idx_d   = 3'd7;
        cnt_d   = '0;
        state_d = BIT;
      end
      BIT: begin
        if (cnt_q != BIT_END) begin
          cnt_d = cnt_q + 1'b1;
        end else if (idx_q != 3'd0) begin
          shift_d = {shift_q[6:0], 1'b0};
          idx_d   = idx_q - 1'b1;
          cnt_d   = '0;
        end else if (!empty) begin
          // Chain straight into the next byte, no LOAD gap
          pop     = 1'b1;
          shift_d = head;
          idx_d   = 3'd7;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (cnt_q == LAT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level computed from next-state so the register lines up with cnt
  always_comb begin
    hi = 1'b0;
    if (state_d == BIT) begin
      hi = (cnt_d < (shift_d[7] ? T1H_C : T0H_C));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      led_q   <= INV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      led_q   <= hi ^ INV;
    end
  end

  assign led_out    = led_q;
  assign in_ready   = !full;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_level = count;

endmodule
